debug_run_controller: RTL and testbench
=======================================

Name: debug_run_controller

Overview:
- Sequences the MIPS pipeline for the debug path: free-run, single-step, automatic halt on HALT opcode, pipeline drain.
- Shares register-file read port 1 between the decode stage and a register-dump engine that streams all GPRs out via a valid/ready link toward the UART transmitter.
- Sits beside decode; drives the global pipeline enable and the read-port-1 address mux.

Parameters:
- len, 32, datapath/word width
- NB, $clog2(len), register address width
- N_REGS, 32, registers dumped (index 0..N_REGS-1)
- DRAIN_CYCLES, 4, enabled cycles after HALT detection so younger stages retire
- HALT_OPCODE, 6'b111111, opcode field value treated as HALT

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  debug command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
- cmd_code  in  2  00 RUN, 01 STEP, 10 DUMP, 11 STOP
- in_instruccion  in  len  instruction currently in decode
- pipe_enable  out  1  global pipeline stage enable
- dbg_reg_sel  out  1  1 = read port 1 addressed by this block
- dbg_read_register  out  NB  register index driven to read port 1
- read_data_1  in  len  register file read data, port 1
- tx_valid  out  1  dump word valid
- tx_data  out  len  dump word
- tx_ready  in  1  downstream accepts word
- cycle_count  out  32  enabled cycles since reset
- halted  out  1  HALT retired; sticky until reset
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE; pipe_enable 0, dbg_reg_sel 0, dbg_read_register 0, tx_valid 0, tx_data 0, cycle_count 0, halted 0, busy 0. cmd_ready combinational from state, so 1 immediately after reset.
- States: IDLE, RUN, STEP, DRAIN, DUMP_ADDR, DUMP_SEND. All outputs registered except cmd_ready, busy.
- cmd_ready = 1 in IDLE and RUN; 0 otherwise. In RUN only STOP has effect; other codes accepted and dropped.
- IDLE: RUN -> RUN; STEP -> STEP; DUMP -> DUMP_ADDR with index 0; STOP -> no effect. If halted=1, RUN/STEP accepted and ignored (stay IDLE); DUMP permitted.
- RUN: pipe_enable=1 every cycle. in_instruccion[31:26]==HALT_OPCODE -> DRAIN, counter loaded with DRAIN_CYCLES. Accepted STOP -> IDLE next cycle; pipe_enable 0 from that cycle. STOP and HALT in same cycle: HALT wins (DRAIN).
- STEP: pipe_enable=1 for exactly one cycle; HALT opcode in that cycle -> DRAIN, else -> IDLE.
- DRAIN: pipe_enable=1 for DRAIN_CYCLES cycles, then halted<=1, pipe_enable 0, -> IDLE. Further HALT opcodes ignored. DRAIN_CYCLES=0: straight to IDLE with halted set.
- DUMP_ADDR: pipe_enable 0, dbg_reg_sel 1, dbg_read_register=index; one cycle (register read latency), then -> DUMP_SEND with tx_data<=read_data_1, tx_valid<=1.
- DUMP_SEND: tx_valid and tx_data stable until tx_ready. On handshake: if index==N_REGS-1 -> IDLE (tx_valid 0, dbg_reg_sel 0); else index+1 -> DUMP_ADDR. No wrap-around; exactly N_REGS words per DUMP.
- cycle_count: +1 on every cycle pipe_enable=1; saturates at 32'hFFFFFFFF.
- Reset mid-DUMP or mid-DRAIN: immediate return to reset values; no partial-word completion guaranteed.

Optional Feature:
- DEBUG_DUMP_CYCLES_EN defined: after register N_REGS-1, one extra DUMP_SEND word with tx_data=cycle_count (value sampled at dump start); dump = N_REGS+1 words.
- Undefined: dump is exactly N_REGS words; cycle_count available only on its port.

Test Plan:
- Reset during RUN -> pipe_enable 0, cycle_count 0, cmd_ready 1 in the same cycle reset asserts.
- RUN, HALT opcode in decode at cycle 10 -> pipe_enable high for 10+DRAIN_CYCLES(4)=14 cycles, halted=1, cycle_count=14; subsequent RUN leaves pipe_enable 0.
- Three STEP commands, no HALT -> three single-cycle pipe_enable pulses, cycle_count=3, halted 0.
- RUN then STOP after 5 cycles -> pipe_enable low the cycle after STOP acceptance, cycle_count=5.
- Registers preloaded r[i]=i*4, DUMP with tx_ready toggling 1/0 -> 32 words 0,4,...,124 in order, tx_data stable while tx_ready=0, dbg_reg_sel low afterwards; with DEBUG_DUMP_CYCLES_EN, 33rd word equals cycle_count.
- Reset asserted during 7th dump word -> tx_valid 0 immediately; new DUMP restarts at r0.

Source files
------------

// File: rtl/debug_run_controller.sv
// Debug run controller: free-run / single-step / HALT drain sequencing and GPR dump over valid/ready.
// Define DEBUG_DUMP_CYCLES_EN to append the cycle count (sampled at dump start) as an extra dump word.
module debug_run_controller #(
  parameter int         len          = 32,
  parameter int         NB           = $clog2(len),
  parameter int         N_REGS       = 32,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [5:0] HALT_OPCODE  = 6'b111111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_code,
  input  logic [len-1:0] in_instruccion,
  output logic          pipe_enable,
  output logic          dbg_reg_sel,
  output logic [NB-1:0] dbg_read_register,
  input  logic [len-1:0] read_data_1,
  output logic          tx_valid,
  output logic [len-1:0] tx_data,
  input  logic          tx_ready,
  output logic [31:0]   cycle_count,
  output logic          halted,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, DUMP_ADDR, DUMP_SEND} state_t;

  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_DUMP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
`ifdef DEBUG_DUMP_CYCLES_EN
  localparam int LAST_IDX = N_REGS;
`else
  localparam int LAST_IDX = N_REGS - 1;
`endif
  localparam int IW = (LAST_IDX < 1) ? 1 : $clog2(LAST_IDX + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [IW-1:0]   index_q, index_d;
  logic            halted_q, halted_d;
  logic            pipe_enable_q, pipe_enable_d;
  logic            dbg_reg_sel_q, dbg_reg_sel_d;
  logic [NB-1:0]   dbg_read_register_q, dbg_read_register_d;
  logic            tx_valid_q, tx_valid_d;
  logic [len-1:0]  tx_data_q, tx_data_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
`ifdef DEBUG_DUMP_CYCLES_EN
  logic [31:0]     snap_q, snap_d;
`endif

  logic accept;
  logic is_halt;
  logic start_drain;
  logic unused_instr_bits;

  assign accept            = cmd_valid && cmd_ready;
  assign is_halt           = (in_instruccion[len-1 -: 6] == HALT_OPCODE);
  assign unused_instr_bits = ^in_instruccion[len-7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      drain_cnt_q         <= '0;
      index_q             <= '0;
      halted_q            <= 1'b0;
      pipe_enable_q       <= 1'b0;
      dbg_reg_sel_q       <= 1'b0;
      dbg_read_register_q <= '0;
      tx_valid_q          <= 1'b0;
      tx_data_q           <= '0;
      cycle_count_q       <= '0;
`ifdef DEBUG_DUMP_CYCLES_EN
      snap_q              <= '0;
`endif
    end else begin
      state_q             <= state_d;
      drain_cnt_q         <= drain_cnt_d;
      index_q             <= index_d;
      halted_q            <= halted_d;
      pipe_enable_q       <= pipe_enable_d;
      dbg_reg_sel_q       <= dbg_reg_sel_d;
      dbg_read_register_q <= dbg_read_register_d;
      tx_valid_q          <= tx_valid_d;
      tx_data_q           <= tx_data_d;
      cycle_count_q       <= cycle_count_d;
`ifdef DEBUG_DUMP_CYCLES_EN
      snap_q              <= snap_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    index_d     = index_q;
    halted_d    = halted_q;
    start_drain = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_code)
            CMD_RUN:  if (!halted_q) state_d = RUN;
            CMD_STEP: if (!halted_q) state_d = STEP;
            CMD_DUMP: begin
              state_d = DUMP_ADDR;
              index_d = '0;
            end
            default:  state_d = IDLE;
          endcase
        end
      end
      // HALT beats a STOP arriving in the same cycle.
      RUN: begin
        if (is_halt) begin
          start_drain = 1'b1;
        end else if (accept && cmd_code == CMD_STOP) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (is_halt) begin
          start_drain = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (drain_cnt_q <= CW'(1)) begin
          state_d  = IDLE;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - CW'(1);
        end
      end
      DUMP_ADDR: state_d = DUMP_SEND;
      DUMP_SEND: begin
        if (tx_ready) begin
          if (index_q == IW'(LAST_IDX)) begin
            state_d = IDLE;
          end else begin
            index_d = index_q + IW'(1);
            state_d = DUMP_ADDR;
`ifdef DEBUG_DUMP_CYCLES_EN
            // The cycle-count word needs no register read, so skip DUMP_ADDR.
            if (index_q == IW'(N_REGS - 1)) state_d = DUMP_SEND;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_drain) begin
      if (DRAIN_CYCLES == 0) begin
        state_d  = IDLE;
        halted_d = 1'b1;
      end else begin
        state_d     = DRAIN;
        drain_cnt_d = CW'(DRAIN_CYCLES);
      end
    end
  end

  always_comb begin
    cmd_ready           = (state_q == IDLE) || (state_q == RUN);
    busy                = (state_q != IDLE);
    pipe_enable_d       = (state_d == RUN) || (state_d == STEP) || (state_d == DRAIN);
    dbg_reg_sel_d       = (state_d == DUMP_ADDR) || (state_d == DUMP_SEND);
    dbg_read_register_d = dbg_reg_sel_d ? NB'(index_d) : '0;
    tx_valid_d          = (state_d == DUMP_SEND);
    tx_data_d           = tx_data_q;
    if (state_q == DUMP_ADDR) begin
      tx_data_d = read_data_1;
    end
`ifdef DEBUG_DUMP_CYCLES_EN
    else if (state_q == DUMP_SEND && state_d == DUMP_SEND && index_d == IW'(N_REGS)) begin
      tx_data_d = len'(snap_q);
    end
    snap_d = (state_q == IDLE && state_d == DUMP_ADDR) ? cycle_count_q : snap_q;
`endif
    cycle_count_d = (pipe_enable_q && cycle_count_q != 32'hFFFF_FFFF)
                    ? cycle_count_q + 32'd1 : cycle_count_q;
  end

  assign pipe_enable       = pipe_enable_q;
  assign dbg_reg_sel       = dbg_reg_sel_q;
  assign dbg_read_register = dbg_read_register_q;
  assign tx_valid          = tx_valid_q;
  assign tx_data           = tx_data_q;
  assign cycle_count       = cycle_count_q;
  assign halted            = halted_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Self-checking bench for debug_run_controller: table-driven run/step/halt vectors
// plus hand-written dump, reset-during-run and reset-during-dump sequences.
module tb_debug_run_controller;

  localparam logic [1:0] C_RUN  = 2'b00;
  localparam logic [1:0] C_STEP = 2'b01;
  localparam logic [1:0] C_DUMP = 2'b10;
  localparam logic [1:0] C_STOP = 2'b11;
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
  localparam logic [31:0] NOP_INSTR  = 32'hFBFF_FFFF;
`ifdef DEBUG_DUMP_CYCLES_EN
  localparam int NWORDS = 33;
`else
  localparam int NWORDS = 32;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_code;
  logic [31:0] in_instruccion;
  logic        pipe_enable;
  logic        dbg_reg_sel;
  logic [4:0]  dbg_read_register;
  logic [31:0] read_data_1;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic [31:0] cycle_count;
  logic        halted;
  logic        busy;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        cv;
    logic [1:0]  code;
    logic        halt;
    logic        pe;
    logic        rdy;
    logic        bsy;
    logic        hlt;
    logic [31:0] cc;
  } vec_t;

  vec_t vecs [23];

  debug_run_controller dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .in_instruccion    (in_instruccion),
    .pipe_enable       (pipe_enable),
    .dbg_reg_sel       (dbg_reg_sel),
    .dbg_read_register (dbg_read_register),
    .read_data_1       (read_data_1),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .cycle_count       (cycle_count),
    .halted            (halted),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: preloaded r[i] = i*4, garbage when the port belongs to decode.
  assign read_data_1 = dbg_reg_sel ? regs[dbg_read_register] : 32'hBAD0_BAD0;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic doReset();
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_code       = C_RUN;
    tx_ready       = 1'b0;
    in_instruccion = NOP_INSTR;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sendCmd(input logic [1:0] code);
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    cmd_valid      = v.cv;
    cmd_code       = v.code;
    in_instruccion = v.halt ? HALT_INSTR : NOP_INSTR;
    @(negedge clk);
    checkOutput($sformatf("vec%0d pipe_enable", idx), {31'd0, pipe_enable}, {31'd0, v.pe});
    checkOutput($sformatf("vec%0d cmd_ready", idx), {31'd0, cmd_ready}, {31'd0, v.rdy});
    checkOutput($sformatf("vec%0d busy", idx), {31'd0, busy}, {31'd0, v.bsy});
    checkOutput($sformatf("vec%0d halted", idx), {31'd0, halted}, {31'd0, v.hlt});
    checkOutput($sformatf("vec%0d cycle_count", idx), cycle_count, v.cc);
  endtask

  initial begin
    int nwords;
    int pe_cnt;
    logic prev_stall;
    logic [31:0] prev_data;
    logic [31:0] exp_word;
    logic hit;

    for (int i = 0; i < 32; i++) regs[i] = i * 4;

    //            cv    code    halt  pe    rdy   busy  hlt   cc
    vecs[0]  = '{1'b1, C_STEP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, C_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1};
    vecs[2]  = '{1'b1, C_STEP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, C_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[4]  = '{1'b1, C_STEP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, C_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3};
    vecs[6]  = '{1'b1, C_RUN,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3};
    vecs[7]  = '{1'b0, C_RUN,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, C_RUN,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5};
    vecs[9]  = '{1'b0, C_RUN,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd6};
    vecs[10] = '{1'b0, C_RUN,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd7};
    vecs[11] = '{1'b1, C_STOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8};
    vecs[12] = '{1'b1, C_STOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8};
    vecs[13] = '{1'b1, C_RUN,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd8};
    vecs[14] = '{1'b1, C_STEP, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd9};
    vecs[15] = '{1'b1, C_STOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10};
    vecs[16] = '{1'b0, C_RUN,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd11};
    vecs[17] = '{1'b0, C_RUN,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12};
    vecs[18] = '{1'b0, C_RUN,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd13};
    vecs[19] = '{1'b0, C_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd14};
    vecs[20] = '{1'b1, C_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd14};
    vecs[21] = '{1'b1, C_STEP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd14};
    vecs[22] = '{1'b0, C_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd14};

    doReset();
    checkOutput("reset pipe_enable", {31'd0, pipe_enable}, 32'd0);
    checkOutput("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset cycle_count", cycle_count, 32'd0);
    checkOutput("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset tx_data", tx_data, 32'd0);
    checkOutput("reset dbg_reg_sel", {31'd0, dbg_reg_sel}, 32'd0);
    checkOutput("reset dbg_read_register", {27'd0, dbg_read_register}, 32'd0);

    for (int i = 0; i < 23; i++) applyStimulus(vecs[i], i);
    cmd_valid      = 1'b0;
    in_instruccion = NOP_INSTR;

    // Dump while halted with tx_ready toggling; cycle_count is 14 at dump start.
    $display("[TB] dump with toggling tx_ready");
    sendCmd(C_DUMP);
    nwords     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 400 && nwords < NWORDS; c++) begin
      if (prev_stall) begin
        checkOutput("stall tx_valid held", {31'd0, tx_valid}, 32'd1);
        checkOutput("stall tx_data held", tx_data, prev_data);
      end
      tx_ready = ~tx_ready;
      if (tx_valid && tx_ready) begin
        exp_word = (nwords < 32) ? nwords * 4 : 32'd14;
        checkOutput($sformatf("dump word %0d", nwords), tx_data, exp_word);
        nwords++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    @(negedge clk);
    checkOutput("dump word count", nwords, NWORDS);
    checkOutput("post-dump tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("post-dump dbg_reg_sel", {31'd0, dbg_reg_sel}, 32'd0);
    checkOutput("post-dump busy", {31'd0, busy}, 32'd0);

    // Reset asserted mid-cycle while running takes effect without a clock edge.
    doReset();
    sendCmd(C_RUN);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset pipe_enable", {31'd0, pipe_enable}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset pipe_enable", {31'd0, pipe_enable}, 32'd0);
    checkOutput("async reset cycle_count", cycle_count, 32'd0);
    checkOutput("async reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // HALT in the 10th enabled cycle gives 10 + 4 drain cycles.
    $display("[TB] halt at cycle 10");
    sendCmd(C_RUN);
    pe_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (pipe_enable) pe_cnt++;
      in_instruccion = (pipe_enable && pe_cnt == 10) ? HALT_INSTR : NOP_INSTR;
      @(negedge clk);
    end
    in_instruccion = NOP_INSTR;
    checkOutput("halt enabled cycles", pe_cnt, 32'd14);
    checkOutput("halt halted", {31'd0, halted}, 32'd1);
    checkOutput("halt cycle_count", cycle_count, 32'd14);
    sendCmd(C_RUN);
    for (int c = 0; c < 3; c++) begin
      checkOutput("run after halt pipe_enable", {31'd0, pipe_enable}, 32'd0);
      @(negedge clk);
    end

    // Reset during the 7th dump word, then a fresh dump restarts at r0.
    $display("[TB] reset during dump");
    doReset();
    tx_ready = 1'b1;
    sendCmd(C_DUMP);
    nwords = 0;
    hit    = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (tx_valid) begin
        if (nwords == 6) begin
          #2 reset = 1'b1;
          #1;
          checkOutput("mid-dump reset tx_valid", {31'd0, tx_valid}, 32'd0);
          checkOutput("mid-dump reset dbg_reg_sel", {31'd0, dbg_reg_sel}, 32'd0);
          checkOutput("mid-dump reset busy", {31'd0, busy}, 32'd0);
          hit = 1'b1;
        end else begin
          checkOutput($sformatf("pre-reset word %0d", nwords), tx_data, nwords * 4);
          nwords++;
        end
      end
      if (!hit) @(negedge clk);
    end
    if (!hit) checkOutput("mid-dump reset reached", 32'd0, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tx_ready = 1'b1;
    sendCmd(C_DUMP);
    nwords = 0;
    for (int c = 0; c < 100 && nwords < 3; c++) begin
      if (tx_valid) begin
        checkOutput($sformatf("restart word %0d", nwords), tx_data, nwords * 4);
        nwords++;
      end
      @(negedge clk);
    end
    checkOutput("restart word count", nwords, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
